// File: rtl/ntt_stage_sequencer_if.sv
// Handshake bundle between the NTT stage sequencer and its controller.
// The master drives requests and the count; the slave returns stage status.
interface ntt_stage_sequencer_if #(
  parameter int CNT_W   = 8,
  parameter int STAGE_W = 4
);
  logic               in_go;
  logic               in_abort;
  logic [CNT_W-1:0]   in_cnt;
  logic               out_cnt_start;
  logic [STAGE_W-1:0] out_stage;
  logic               out_swap;
  logic               out_busy;
  logic               out_done;

  modport master (
    output in_go, in_abort, in_cnt,
    input  out_cnt_start, out_stage, out_swap,
    input  out_busy, out_done
  );

  modport slave (
    input  in_go, in_abort, in_cnt,
    output out_cnt_start, out_stage, out_swap,
    output out_busy, out_done
  );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// Runs NUM_STAGES butterfly passes: launch the stage counter, wait for
// its last count, drain the pipeline, then advance stage and buffer select.
module ntt_stage_sequencer #(
  parameter int NUM_STAGES = 11,
  parameter int STAGE_W    = 4,
  parameter int CNT_W      = 8,
  parameter int CNT_MAX    = 255,
  parameter int DRAIN_CYC  = 16,
  parameter int DRAIN_W    = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  ntt_stage_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [STAGE_W-1:0] LAST  = STAGE_W'(NUM_STAGES - 1);
  localparam logic [STAGE_W-1:0] ONE   = STAGE_W'(1);
  localparam logic [CNT_W-1:0]   CMAX  = CNT_W'(CNT_MAX);
  localparam logic [DRAIN_W-1:0] DLOAD = DRAIN_W'(DRAIN_CYC - 1);
  localparam logic [DRAIN_W-1:0] DONE1 = DRAIN_W'(1);

  state_t             state;
  logic [DRAIN_W-1:0] drain;
  logic [STAGE_W-1:0] stage;
  logic               swap;
  logic               cnt_start;
  logic               busy;
  logic               done;

  assign bus.out_cnt_start = cnt_start;
  assign bus.out_stage     = stage;
  assign bus.out_swap      = swap;
  assign bus.out_busy      = busy;
  assign bus.out_done      = done;

  // Outputs are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain     <= '0;
      stage     <= '0;
      swap      <= 1'b0;
      cnt_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cnt_start <= 1'b0;
      done      <= 1'b0;
      if (state != IDLE && bus.in_abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.in_go) begin
              state     <= LAUNCH;
              stage     <= '0;
              swap      <= 1'b0;
              cnt_start <= 1'b1;
              busy      <= 1'b1;
            end
          end
          LAUNCH: state <= RUN;
          RUN: begin
            if (bus.in_cnt == CMAX) begin
              state <= DRAIN;
              drain <= DLOAD;
            end
          end
          DRAIN: begin
            if (drain == '0) begin
              if (stage == LAST) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state     <= LAUNCH;
                stage     <= stage + ONE;
                swap      <= ~swap;
                cnt_start <= 1'b1;
              end
            end else begin
              drain <= drain - DONE1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench for the stage sequencer: default build and a 2-stage, 1-cycle-drain
// build, both checked every cycle against a time-offset schedule model.
module tb_ntt_stage_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ntt_stage_sequencer_if #(.CNT_W(8), .STAGE_W(4)) ia ();
  ntt_stage_sequencer_if #(.CNT_W(8), .STAGE_W(4)) ib ();

  ntt_stage_sequencer dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia)
  );

  ntt_stage_sequencer #(
    .NUM_STAGES (2),
    .DRAIN_CYC  (1)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib)
  );

  int NS [2]  = '{11, 2};
  int PER [2] = '{273, 258};

  logic       go [2]    = '{1'b0, 1'b0};
  logic       abort [2] = '{1'b0, 1'b0};
  logic [7:0] cnt [2]   = '{8'd0, 8'd0};
  logic       run [2]   = '{1'b0, 1'b0};

  logic       d_start [2];
  logic       d_busy [2];
  logic       d_done [2];
  logic       d_swap [2];
  logic [3:0] d_stage [2];

  assign ia.in_go    = go[0];
  assign ia.in_abort = abort[0];
  assign ia.in_cnt   = cnt[0];
  assign ib.in_go    = go[1];
  assign ib.in_abort = abort[1];
  assign ib.in_cnt   = cnt[1];

  assign d_start[0] = ia.out_cnt_start;
  assign d_busy[0]  = ia.out_busy;
  assign d_done[0]  = ia.out_done;
  assign d_swap[0]  = ia.out_swap;
  assign d_stage[0] = ia.out_stage;
  assign d_start[1] = ib.out_cnt_start;
  assign d_busy[1]  = ib.out_busy;
  assign d_done[1]  = ib.out_done;
  assign d_swap[1]  = ib.out_swap;
  assign d_stage[1] = ib.out_stage;

  // Butterfly counter: restart at 0 on start, count up, park at 255.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (d_start[i]) begin
        cnt[i] <= 8'd0;
        run[i] <= 1'b1;
      end else if (run[i] && cnt[i] != 8'd255) begin
        cnt[i] <= cnt[i] + 8'd1;
      end
    end
  end

  int ecount = 0;
  int g [2] = '{0, 0};
  bit m_busy [2]  = '{0, 0};
  bit m_start [2] = '{0, 0};
  bit m_done [2]  = '{0, 0};
  int m_stage [2] = '{0, 0};
  int m_swap [2]  = '{0, 0};

  // Schedule model: outputs follow from cycles elapsed since go was taken.
  always @(posedge clk) begin
    ecount++;
    for (int i = 0; i < 2; i++) begin
      int o;
      int last;
      last = NS[i] * PER[i];
      m_start[i] = 0;
      m_done[i] = 0;
      if (!rst_n) begin
        m_busy[i] = 0;
        m_stage[i] = 0;
      end else if (m_busy[i] && abort[i]) begin
        m_busy[i] = 0;
      end else if (m_busy[i]) begin
        o = ecount - g[i];
        if (o > last) begin
          m_busy[i] = 0;
        end else begin
          m_stage[i] = (o / PER[i] < NS[i]) ? o / PER[i] : NS[i] - 1;
          m_start[i] = (o < last) && (o % PER[i] == 0);
          m_done[i] = (o == last);
        end
      end else if (go[i]) begin
        m_busy[i] = 1;
        g[i] = ecount;
        m_stage[i] = 0;
        m_start[i] = 1;
      end
      m_swap[i] = m_stage[i] % 2;
    end
  end

  int compared = 0;
  int mismatched = 0;
  int n_start [2] = '{0, 0};
  int done_edge [2] = '{-1, -1};

  function automatic void check(string name, int i, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s dut%0d edge %0d: got %0d expected %0d",
               name, i, ecount, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check("busy", i, int'(d_busy[i]), int'(m_busy[i]));
      check("cnt_start", i, int'(d_start[i]), int'(m_start[i]));
      check("done", i, int'(d_done[i]), int'(m_done[i]));
      check("stage", i, int'(d_stage[i]), m_stage[i]);
      check("swap", i, int'(d_swap[i]), m_swap[i]);
      if (d_start[i]) n_start[i]++;
      if (d_done[i]) done_edge[i] = ecount;
    end
  end

  task automatic pulse_go(input int i, output int ref_edge);
    @(negedge clk);
    ref_edge = ecount;
    go[i] = 1'b1;
    @(negedge clk);
    go[i] = 1'b0;
  endtask

  task automatic wait_edge(input int e);
    while (ecount < e) @(negedge clk);
  endtask

  task automatic wait_idle(input int i, input int budget, output int idle_edge);
    int n;
    n = 0;
    while (d_busy[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    idle_edge = ecount;
    if (d_busy[i]) check("idle_timeout", i, 1, 0);
  endtask

  task automatic clear_marks();
    n_start = '{0, 0};
    done_edge = '{-1, -1};
  endtask

  initial begin
    int r;
    int ie;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 0, int'(d_busy[0]), 0);
    check("rst_stage", 0, int'(d_stage[0]), 0);

    // Full run on both builds together.
    clear_marks();
    @(negedge clk);
    r = ecount;
    go[0] = 1'b1;
    go[1] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    go[1] = 1'b0;
    check("launch_busy", 0, int'(d_busy[0]), 1);
    check("launch_start", 0, int'(d_start[0]), 1);
    wait_idle(0, 3200, ie);
    check("run1_starts", 0, n_start[0], 11);
    check("run1_done_edge", 0, done_edge[0] - r, 3004);
    check("run1_idle_edge", 0, ie - r, 3005);
    check("b_starts", 1, n_start[1], 2);
    check("b_done_edge", 1, done_edge[1] - r, 517);

    // Go during RUN of stage 3 must not disturb the schedule.
    clear_marks();
    pulse_go(0, r);
    wait_edge(r + 1 + 273 * 3 + 100);
    go[0] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    wait_idle(0, 3200, ie);
    check("run2_starts", 0, n_start[0], 11);
    check("run2_done_edge", 0, done_edge[0] - r, 3004);

    // Abort during DRAIN of stage 5, then a clean restart.
    clear_marks();
    pulse_go(0, r);
    wait_edge(r + 273 * 5 + 260);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check("abort_busy", 0, int'(d_busy[0]), 0);
    repeat (20) @(negedge clk);
    check("abort_no_done", 0, done_edge[0], -1);
    clear_marks();
    pulse_go(0, r);
    check("restart_stage", 0, int'(d_stage[0]), 0);
    check("restart_swap", 0, int'(d_swap[0]), 0);
    wait_idle(0, 3200, ie);
    check("restart_done_edge", 0, done_edge[0] - r, 3004);

    // Reset during RUN of stage 7.
    clear_marks();
    pulse_go(0, r);
    wait_edge(r + 273 * 7 + 50);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_stage", 0, int'(d_stage[0]), 0);
    check("rst_mid_busy", 0, int'(d_busy[0]), 0);
    n_start[0] = 0;
    repeat (300) @(negedge clk);
    check("rst_no_start", 0, n_start[0], 0);
    check("rst_no_done", 0, done_edge[0], -1);

    // Small build: abort on the edge that would enter DONE.
    clear_marks();
    pulse_go(1, r);
    wait_edge(r + 516);
    abort[1] = 1'b1;
    @(negedge clk);
    abort[1] = 1'b0;
    repeat (5) @(negedge clk);
    check("b_abort_no_done", 1, done_edge[1], -1);
    check("b_abort_busy", 1, int'(d_busy[1]), 0);

    // Random go/abort/reset traffic on both builds.
    for (int c = 0; c < 15000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        go[i] = ($urandom_range(0, 299) == 0);
        abort[i] = ($urandom_range(0, 3999) == 0);
      end
      rst_n = ($urandom_range(0, 19999) != 0);
    end
    @(negedge clk);
    go = '{1'b0, 1'b0};
    abort = '{1'b0, 1'b0};
    rst_n = 1'b1;
    wait_idle(0, 3200, ie);
    wait_idle(1, 3200, ie);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ntt_stage_sequencer.md
Name: ntt_stage_sequencer

Overview:
- Upstream controller for the 8-bit per-stage butterfly counter (start input, free-running count 0..255, self-stop at 255, registered count output).
- On a go pulse it runs NUM_STAGES NTT passes, 11 by default for n=2048.
- Per pass: one-cycle counter start pulse, watch the returned count until CNT_MAX, wait a fixed pipeline-drain interval, advance the stage index and toggle the ping-pong buffer select.
- Reports busy, current stage and a one-cycle done pulse to the top-level NTT control.

Parameters:
- NUM_STAGES, 11, passes per transform (log2 n).
- STAGE_W, 4, width of stage index; 2^STAGE_W >= NUM_STAGES.
- CNT_W, 8, width of count input.
- CNT_MAX, 255, count value marking the last butterfly cycle of a pass.
- DRAIN_CYC, 16, idle cycles after CNT_MAX for the butterfly/memory pipeline to drain; must be >= 1.
- DRAIN_W, 5, drain counter width; 2^DRAIN_W > DRAIN_CYC.

Ports:
- clk, in, 1, clock; all logic on posedge.
- rst_n, in, 1, synchronous active-low reset.
- in_go, in, 1, one-cycle request to start a full transform; honoured only in IDLE.
- in_abort, in, 1, cancel the transform in progress; returns to IDLE.
- in_cnt, in, CNT_W, count value from the stage counter.
- out_cnt_start, out, 1, start pulse to the stage counter.
- out_stage, out, STAGE_W, index of the stage being executed.
- out_swap, out, 1, ping-pong buffer select; toggles between stages.
- out_busy, out, 1, high in every state except IDLE.
- out_done, out, 1, one-cycle pulse when the final stage has drained.

Behaviour:
- Reset (rst_n=0 at a posedge):
  - state=IDLE, out_stage=0, out_swap=0, drain counter=0.
  - out_cnt_start=0, out_busy=0, out_done=0.
  - Applies mid-operation too: no further start pulses; done is not issued.
- States: IDLE, LAUNCH, RUN, DRAIN, DONE (binary-encoded, registered). Outputs are decoded from state; no combinational path from inputs to outputs.
- IDLE:
  - in_go=1 -> LAUNCH; out_stage<=0, out_swap<=0.
  - in_abort is ignored in IDLE.
- LAUNCH:
  - out_cnt_start=1 for exactly this one cycle.
  - Unconditionally -> RUN, unless in_abort.
- RUN:
  - out_cnt_start=0.
  - When in_cnt==CNT_MAX -> DRAIN; drain counter<=DRAIN_CYC-1.
  - Otherwise stay. No timeout; the counter guarantees termination.
- DRAIN:
  - Drain counter decrements each cycle.
  - When it reads 0:
    - if out_stage==NUM_STAGES-1 -> DONE;
    - else out_stage<=out_stage+1, out_swap<=~out_swap, -> LAUNCH.
  - DRAIN therefore lasts exactly DRAIN_CYC cycles.
- DONE:
  - out_done=1 for this one cycle.
  - -> IDLE. out_stage and out_swap hold their last values until the next in_go.
- Busy and go:
  - out_busy=1 in LAUNCH, RUN, DRAIN and DONE.
  - in_go while busy is ignored; it is not queued.
- in_abort in LAUNCH, RUN, DRAIN or DONE -> IDLE next cycle; out_done is not pulsed.
  - Abort wins over every other transition, including a DONE->IDLE that coincides.
  - The counter is not stopped; it self-terminates at CNT_MAX.
- Timing with in_go at edge 0 and defaults:
  - LAUNCH in cycle after edge 1; counter samples start at edge 2; count 0..255 after edges 2..257.
  - RUN sees 255 after edge 257 and enters DRAIN at edge 258.
  - Stage period = 1+256+DRAIN_CYC = 273 cycles.
  - Stage k LAUNCH after edge 1+273k; DONE after edge 3004; IDLE at edge 3005.
- Width rules: out_stage increments never exceed NUM_STAGES-1; no wrap inside one transform.

Test Plan:
- Reset, then in_go at edge 0 -> out_busy=1 after edge 1; out_cnt_start high only in cycle 1; out_stage=0; out_swap=0.
- Full run with a counter model:
  - out_cnt_start pulses 11 times, after edges 1, 274, 547, ..., 2731;
  - out_stage steps 0..10 and out_swap toggles at each step;
  - out_done high only after edge 3004; out_busy=0 from edge 3005.
- in_go pulsed during RUN of stage 3 -> ignored; stage sequence and done timing identical to the previous run.
- in_abort during DRAIN of stage 5 -> IDLE next edge, out_busy=0, no out_done; a fresh in_go restarts at stage 0 with out_swap=0.
- rst_n=0 for one cycle during RUN of stage 7 -> all outputs 0 after that edge; no start pulse until the next in_go.
- DRAIN_CYC=1, NUM_STAGES=2 -> stage period 258; out_done after edge 517; in_abort coincident with DONE -> no out_done.
